// File: rtl/softmax_lane_sequencer.sv
// rtl/softmax_lane_sequencer.sv - captures a 10-lane vector, streams it through a 10:1 mux, then presents the lane sum
// Serialiser between the parallel exp stage and the serial normalise stage.

module mux_10_to_1 #(
    parameter int WIDTH = 24
) (
    input  logic [10*WIDTH-1:0] data,
    input  logic [3:0]          sel,
    output logic [WIDTH-1:0]    y
);
    // sel 1..10 picks lane 0..9; any other code yields zero
    always_comb begin
        y = '0;
        case (sel)
            4'd1:    y = data[0*WIDTH +: WIDTH];
            4'd2:    y = data[1*WIDTH +: WIDTH];
            4'd3:    y = data[2*WIDTH +: WIDTH];
            4'd4:    y = data[3*WIDTH +: WIDTH];
            4'd5:    y = data[4*WIDTH +: WIDTH];
            4'd6:    y = data[5*WIDTH +: WIDTH];
            4'd7:    y = data[6*WIDTH +: WIDTH];
            4'd8:    y = data[7*WIDTH +: WIDTH];
            4'd9:    y = data[8*WIDTH +: WIDTH];
            4'd10:   y = data[9*WIDTH +: WIDTH];
            default: y = '0;
        endcase
    end
endmodule

module softmax_lane_sequencer #(
    parameter int DATA_WIDTH = 24,
    parameter int SUM_WIDTH  = DATA_WIDTH + 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [10*DATA_WIDTH-1:0] in_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic                    sum_valid,
    input  logic                    sum_ready,
    output logic [SUM_WIDTH-1:0]    sum_data,
    output logic [3:0]              sel,
    output logic                    busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        SUM    = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              sel_reg;
    logic [3:0]              sel_next;
    logic [SUM_WIDTH-1:0]    acc;
    logic [SUM_WIDTH-1:0]    acc_next;
    logic [10*DATA_WIDTH-1:0] bank;
    logic                    capture;
    logic [DATA_WIDTH-1:0]   lane;

    mux_10_to_1 #(
        .WIDTH (DATA_WIDTH)
    ) u_mux (
        .data (bank),
        .sel  (sel_reg),
        .y    (lane)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel_reg;
        acc_next   = acc;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    capture    = 1'b1;
                    sel_next   = 4'd1;
                    acc_next   = '0;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    acc_next = acc + {{(SUM_WIDTH-DATA_WIDTH){1'b0}}, lane};
                    if (sel_reg == 4'd10) begin
                        sel_next   = 4'd0;
                        state_next = SUM;
                    end else begin
                        sel_next = sel_reg + 4'd1;
                    end
                end
            end
            SUM: begin
                if (sum_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = 4'd0;
            end
        endcase
        // flush overrides any handshake or capture in the same cycle
        if (flush) begin
            state_next = IDLE;
            sel_next   = 4'd0;
            acc_next   = '0;
            capture    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg <= 4'd0;
            acc     <= '0;
            bank    <= '0;
        end else begin
            sel_reg <= sel_next;
            acc     <= acc_next;
            if (capture) begin
                bank <= in_data;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == STREAM);
    assign out_data  = lane;
    assign out_last  = (state == STREAM) && (sel_reg == 4'd10);
    assign sum_valid = (state == SUM);
    assign sum_data  = (state == SUM) ? acc : '0;
    assign sel       = sel_reg;
endmodule

// File: tb/tb_softmax_lane_sequencer.sv
// tb/tb_softmax_lane_sequencer.sv - table-driven and randomized bench for softmax_lane_sequencer
module tb_softmax_lane_sequencer;
    localparam int DW = 24;
    localparam int SW = 28;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [10*DW-1:0] in_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            sum_valid;
    logic            sum_ready;
    logic [SW-1:0]   sum_data;
    logic [3:0]      sel;
    logic            busy;

    int checks = 0;
    int errors = 0;

    softmax_lane_sequencer #(.DATA_WIDTH(DW), .SUM_WIDTH(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .sum_data  (sum_data),
        .sel       (sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10*DW-1:0] vec;
        int               rmode;
        int               sstall;
        bit               hold_next;
        logic [SW-1:0]    exp_sum;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10*DW-1:0] mk_vec(input logic [DW-1:0] base, input logic [DW-1:0] step);
        logic [10*DW-1:0] v;
        v = '0;
        for (int k = 0; k < 10; k++) v[k*DW +: DW] = DW'(base + step * DW'(k));
        return v;
    endfunction

    function automatic logic [SW-1:0] model_sum(input logic [10*DW-1:0] v);
        logic [SW-1:0] s;
        s = '0;
        for (int k = 0; k < 10; k++) s = s + SW'(v[k*DW +: DW]);
        return s;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_sum_valid"}, sum_valid, 0);
        chk({tag, "_sum_data"}, sum_data, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Called at a falling edge with the DUT expected idle; returns at a falling edge, idle again.
    task automatic run_vec(input int id, input logic [10*DW-1:0] vec, input int rmode,
                           input int sstall, input bit hold_next,
                           input logic [10*DW-1:0] next_vec, input logic [SW-1:0] exp_sum);
        int idx = 0;
        int cyc = 0;
        logic [DW-1:0] exp_lane;
        chk($sformatf("v%0d_start_ready", id), in_ready, 1);
        in_valid  = 1'b1;
        in_data   = vec;
        out_ready = 1'b0;
        @(negedge clk);
        while (idx < 10 && cyc < 200) begin
            exp_lane = vec[idx*DW +: DW];
            chk($sformatf("v%0d_valid%0d", id, idx), out_valid, 1);
            chk($sformatf("v%0d_lane%0d", id, idx), out_data, exp_lane);
            chk($sformatf("v%0d_last%0d", id, idx), out_last, (idx == 9));
            chk($sformatf("v%0d_sel%0d", id, idx), sel, idx + 1);
            chk($sformatf("v%0d_busy_ready%0d", id, idx), in_ready, 0);
            if (hold_next) begin
                in_valid = 1'b1;
                in_data  = next_vec;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {8{$urandom()}};
            end
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'(cyc % 2);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk($sformatf("v%0d_lane_budget", id), idx, 10);
        if (rmode == 0) chk($sformatf("v%0d_latency", id), cyc, 10);
        for (int s = 0; s <= sstall; s++) begin
            chk($sformatf("v%0d_sum_valid%0d", id, s), sum_valid, 1);
            chk($sformatf("v%0d_sum_data%0d", id, s), sum_data, exp_sum);
            chk($sformatf("v%0d_sum_outv%0d", id, s), out_valid, 0);
            chk($sformatf("v%0d_sum_outd%0d", id, s), out_data, 0);
            chk($sformatf("v%0d_sum_sel%0d", id, s), sel, 0);
            chk($sformatf("v%0d_sum_inrdy%0d", id, s), in_ready, 0);
            sum_ready = (s == sstall);
            if (s == sstall && !hold_next) in_valid = 1'b0;
            @(negedge clk);
        end
        sum_ready = 1'b0;
        if (!hold_next) in_valid = 1'b0;
        chk($sformatf("v%0d_end_ready", id), in_ready, 1);
        chk($sformatf("v%0d_end_sumv", id), sum_valid, 0);
        chk($sformatf("v%0d_end_busy", id), busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [10*DW-1:0] rv;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
        out_ready = 1'b0; sum_ready = 1'b0;

        tbl[0] = '{mk_vec(24'd1, 24'd1),      0, 0, 1'b0, 28'd55};
        tbl[1] = '{mk_vec(24'd1, 24'd1),      1, 5, 1'b0, 28'd55};
        tbl[2] = '{mk_vec(24'hFFFFFF, 24'd0), 0, 0, 1'b0, 28'h9FFFFF6};
        tbl[3] = '{mk_vec(24'd3, 24'd3),      0, 1, 1'b1, 28'd165};
        tbl[4] = '{mk_vec(24'd100, 24'd1),    0, 0, 1'b0, 28'd1045};
        tbl[5] = '{mk_vec(24'd2, 24'd0),      2, 2, 1'b0, 28'd20};

        repeat (3) @(negedge clk);
        chk_idle("reset_hold");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("reset_release");

        for (int i = 0; i < 6; i++) begin
            run_vec(i, tbl[i].vec, tbl[i].rmode, tbl[i].sstall, tbl[i].hold_next,
                    (i < 5) ? tbl[i+1].vec : '0, tbl[i].exp_sum);
        end

        // flush on the 4th lane handshake
        in_valid = 1'b1; in_data = mk_vec(24'd5, 24'd0); out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_sel_before_flush", sel, 4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk_idle("t5_after_flush");
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("t5_no_sum%0d", c), sum_valid, 0);
            @(negedge clk);
        end
        flush = 1'b1; in_valid = 1'b1; in_data = mk_vec(24'd9, 24'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk_idle("t5_flush_capture");
        out_ready = 1'b0;
        run_vec(20, mk_vec(24'd2, 24'd0), 0, 0, 1'b0, '0, 28'd20);

        // asynchronous reset mid-stream
        in_valid = 1'b1; in_data = mk_vec(24'd7, 24'd1); out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_sel_before_rst", sel, 6);
        chk("t6_lane_before_rst", out_data, 24'd12);
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #1 chk_idle("t6_async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("t6_after_rst");
        run_vec(21, mk_vec(24'd1, 24'd1), 0, 0, 1'b0, '0, 28'd55);

        for (int r = 0; r < 20; r++) begin
            rv = '0;
            for (int k = 0; k < 10; k++)
                rv[k*DW +: DW] = ($urandom_range(0, 3) == 0) ? {DW{1'b1}} : DW'($urandom());
            run_vec(100 + r, rv, 2, $urandom_range(0, 3), 1'b0, '0, model_sum(rv));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
